// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM port arbiter: word type, RAM handshake state,
// arbiter FSM states, operation encoding and burst address stride.
package ram_arbiter_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} arb_state_t;
    typedef enum logic {RD = 1'b0, WR = 1'b1} arb_op_t;

    localparam word_t WORD_STRIDE = 32'd4;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters plus RAM model view.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req_ren;
    logic [NREQ-1:0] req_wen;
    logic [NREQ-1:0] req_burst;
    word_t           req_addr  [NREQ];
    word_t           req_store [NREQ];
    logic [NREQ-1:0] req_wait;
    word_t           req_load  [NREQ];
    logic [NREQ-1:0] req_err;
    logic [IW-1:0]   gnt_id;
    logic            busy;
    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    modport slave (
        input  req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, req_err, gnt_id, busy, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, req_err, gnt_id, busy, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first active
// index strictly after 'last', wrapping cyclically.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] active,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    // Lowest index above 'last' wins; otherwise fall back to the lowest at or below it.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (active[i] && (IW'(i) <= last)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (active[i] && (IW'(i) > last)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters with 1/2-word bursts.
// Optional beat abort on a stalled RAM is enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    arb_state_t      state_reg;
    arb_op_t         op_reg;
    logic [IW-1:0]   gnt_reg;
    logic [IW-1:0]   rr_last_reg;
    logic            beat_reg;
    logic            last_beat_reg;
    logic            ren_reg;
    logic            wen_reg;
    word_t           addr_reg;

    logic [NREQ-1:0] active;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            in_xfer;
    logic            access;
    logic            abort;

    assign active  = bus.req_ren | bus.req_wen;
    assign in_xfer = (state_reg == XFER);
    assign access  = in_xfer && (bus.ramstate == ACCESS);

    rr_picker #(.NREQ(NREQ)) u_picker (
        .active (active),
        .last   (rr_last_reg),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_reg;
    // to_cnt_reg holds stalled cycles already elapsed, so the current one is the TIMEOUT-th.
    assign abort = in_xfer && !access && (to_cnt_reg == TW'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= RD;
            gnt_reg       <= '0;
            rr_last_reg   <= IW'(NREQ - 1);
            beat_reg      <= 1'b0;
            last_beat_reg <= 1'b0;
            ren_reg       <= 1'b0;
            wen_reg       <= 1'b0;
            addr_reg      <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_reg       <= pick_idx;
                        addr_reg      <= bus.req_addr[pick_idx];
                        op_reg        <= bus.req_wen[pick_idx] ? WR : RD;
                        ren_reg       <= !bus.req_wen[pick_idx];
                        wen_reg       <= bus.req_wen[pick_idx];
                        last_beat_reg <= bus.req_burst[pick_idx];
                        beat_reg      <= 1'b0;
                        state_reg     <= XFER;
                    end
                end
                XFER: begin
                    if (access) begin
                        ren_reg <= 1'b0;
                        wen_reg <= 1'b0;
                        if (beat_reg == last_beat_reg) begin
                            state_reg   <= IDLE;
                            rr_last_reg <= gnt_reg;
                        end else begin
                            beat_reg  <= 1'b1;
                            addr_reg  <= addr_reg + WORD_STRIDE;
                            state_reg <= GAP;
                        end
                    end else if (abort) begin
                        ren_reg     <= 1'b0;
                        wen_reg     <= 1'b0;
                        state_reg   <= IDLE;
                        rr_last_reg <= gnt_reg;
                    end
                end
                GAP: begin
                    ren_reg   <= (op_reg == RD);
                    wen_reg   <= (op_reg == WR);
                    state_reg <= XFER;
                end
                default: state_reg <= IDLE;
            endcase
`ifdef ARB_TIMEOUT_EN
            if (!in_xfer || access || abort) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
`endif
        end
    end

    assign bus.gnt_id   = gnt_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.ramREN   = ren_reg;
    assign bus.ramWEN   = wen_reg;
    assign bus.ramaddr  = addr_reg;
    assign bus.ramstore = in_xfer ? bus.req_store[gnt_reg] : '0;

    // Only the granted requester sees RAM data and a release; all others hold.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            logic sel;
            assign sel              = in_xfer && (gnt_reg == IW'(gi));
            assign bus.req_load[gi] = sel ? bus.ramload : '0;
            assign bus.req_wait[gi] = !(sel && (access || abort));
            assign bus.req_err[gi]  = sel && abort;
        end
    endgenerate
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level round-robin model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int NREQ = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: one outstanding transaction per requester plus last winner.
    bit    pend    [NREQ];
    bit    t_wr    [NREQ];
    bit    t_burst [NREQ];
    word_t t_addr  [NREQ];
    word_t t_data  [NREQ][2];
    int    model_last = NREQ - 1;

    always #5 clk = ~clk;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(
        .NREQ(NREQ)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int r, input bit wr, input bit burst, input word_t addr,
                           input word_t d0, input word_t d1);
        t_wr[r]          = wr;
        t_burst[r]       = burst;
        t_addr[r]        = addr;
        t_data[r][0]     = d0;
        t_data[r][1]     = d1;
        pend[r]          = 1'b1;
        bus.req_wen[r]   = wr;
        bus.req_ren[r]   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.req_burst[r] = burst;
        bus.req_addr[r]  = addr;
        bus.req_store[r] = d0;
    endtask

    task automatic new_txn(input int r);
        word_t a;
        a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        set_txn(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom);
    endtask

    task automatic drop(input int r);
        bus.req_ren[r] = 1'b0;
        bus.req_wen[r] = 1'b0;
    endtask

    function automatic int exp_winner();
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".ramREN"}, bus.ramREN, 0);
        chk({tag, ".ramWEN"}, bus.ramWEN, 0);
        for (int q = 0; q < NREQ; q++) begin
            chk($sformatf("%s.req_wait%0d", tag, q), bus.req_wait[q], 1);
            chk($sformatf("%s.req_err%0d", tag, q), bus.req_err[q], 0);
            chk($sformatf("%s.req_load%0d", tag, q), bus.req_load[q], 32'd0);
        end
    endtask

    // Runs one complete grant starting from an IDLE cycle; the model picks the winner.
    task automatic serve(input int lat_lo, input int lat_hi, input bit drop_mid,
                         input int rereq_pct, input bit others_en);
        int    g, nb, lat, pick, r;
        word_t a, ld;
        g  = exp_winner();
        nb = t_burst[g] ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            lat = $urandom_range(lat_hi, lat_lo);
            a   = t_addr[g] + 32'(4 * b);
            for (int c = 0; c <= lat; c++) begin
                tick();
                pick = $urandom_range(0, 2);
                if (c == lat)       bus.ramstate = ACCESS;
                else if (pick == 0) bus.ramstate = FREE;
                else if (pick == 1) bus.ramstate = BUSY;
                else                bus.ramstate = ERROR;
                ld = $urandom;
                bus.ramload = ld;
                if (others_en && $urandom_range(0, 4) == 0) begin
                    r = $urandom_range(0, NREQ - 1);
                    if (r != g && !pend[r]) new_txn(r);
                end
                #1;
                chk("busy", bus.busy, 1);
                chk("gnt_id", bus.gnt_id, g);
                chk("ramREN", bus.ramREN, !t_wr[g]);
                chk("ramWEN", bus.ramWEN, t_wr[g]);
                chk("ramaddr", bus.ramaddr, a);
                if (t_wr[g]) chk("ramstore", bus.ramstore, t_data[g][b]);
                for (int q = 0; q < NREQ; q++) begin
                    chk($sformatf("req_wait%0d", q), bus.req_wait[q], !(q == g && c == lat));
                    chk($sformatf("req_load%0d", q), bus.req_load[q], (q == g) ? ld : 32'd0);
                    chk($sformatf("req_err%0d", q), bus.req_err[q], 0);
                end
            end
            if (b == 0 && nb == 2) begin
                tick();
                bus.ramstate     = FREE;
                bus.req_store[g] = t_data[g][1];
                if (drop_mid) drop(g);
                #1;
                chk("gap.busy", bus.busy, 1);
                chk_quiet("gap");
            end
        end
        model_last = g;
        pend[g]    = 1'b0;
        tick();
        bus.ramstate = FREE;
        if ($urandom_range(0, 99) < rereq_pct) new_txn(g);
        else drop(g);
        #1;
        chk("idle.busy", bus.busy, 0);
        chk("idle.gnt_id", bus.gnt_id, g);
        chk_quiet("idle");
    endtask

    initial begin
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_burst = '0;
        bus.ramload   = '0;
        bus.ramstate  = FREE;
        for (int q = 0; q < NREQ; q++) begin
            bus.req_addr[q]  = '0;
            bus.req_store[q] = '0;
            pend[q]          = 1'b0;
        end

        // Reset values
        repeat (3) tick();
        chk("rst.busy", bus.busy, 0);
        chk("rst.gnt_id", bus.gnt_id, 0);
        chk("rst.ramaddr", bus.ramaddr, 32'd0);
        chk("rst.ramstore", bus.ramstore, 32'd0);
        chk_quiet("rst");
        rst = 1'b0;

        // Single read by requester 2, ACCESS after two stalled cycles
        set_txn(2, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        serve(2, 2, 1'b0, 0, 1'b0);

        // Two-word write burst by requester 1
        set_txn(1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_000A, 32'h0000_000B);
        serve(1, 1, 1'b0, 0, 1'b0);

        // All requesters held continuously: rotation through every requester
        for (int q = 0; q < NREQ; q++) set_txn(q, 1'b0, 1'b0, 32'h1000 + 32'(16 * q), 32'h0, 32'h0);
        repeat (NREQ + 1) serve(0, 1, 1'b0, 100, 1'b0);
        while (exp_winner() >= 0) serve(0, 1, 1'b0, 0, 1'b0);

        // Requester 3 drops its read request after beat 0 of a burst
        set_txn(3, 1'b0, 1'b1, 32'h0000_0340, 32'h0, 32'h0);
        serve(0, 2, 1'b1, 0, 1'b0);

        // Burst wrapping the 32-bit address space
        set_txn(0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h9ABC_DEF0);
        serve(1, 1, 1'b0, 0, 1'b0);

        // Reset asserted in the middle of a burst
        set_txn(2, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 32'h0);
        tick();
        bus.ramstate = BUSY;
        #1;
        chk("mid.ramREN", bus.ramREN, 1);
        chk("mid.gnt_id", bus.gnt_id, 2);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.gnt_id", bus.gnt_id, 0);
        chk("mid_rst.ramaddr", bus.ramaddr, 32'd0);
        chk_quiet("mid_rst");
        for (int q = 0; q < NREQ; q++) begin
            drop(q);
            pend[q] = 1'b0;
        end
        model_last = NREQ - 1;
        bus.ramstate = FREE;
        tick();
        rst = 1'b0;
        #1;

`ifdef ARB_TIMEOUT_EN
        // RAM stuck BUSY: beat aborted on the TIMEOUT-th stalled cycle, next requester served
        set_txn(1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h0);
        set_txn(2, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 32'h0);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            bus.ramstate = BUSY;
            #1;
            chk("to.busy", bus.busy, 1);
            chk("to.gnt_id", bus.gnt_id, 1);
            chk($sformatf("to.req_err1@%0d", c), bus.req_err[1], (c == TIMEOUT));
            chk($sformatf("to.req_wait1@%0d", c), bus.req_wait[1], (c != TIMEOUT));
            chk($sformatf("to.req_err2@%0d", c), bus.req_err[2], 0);
        end
        tick();
        bus.ramstate = FREE;
        drop(1);
        pend[1]    = 1'b0;
        model_last = 1;
        #1;
        chk("to.idle.busy", bus.busy, 0);
        chk_quiet("to.idle");
        serve(0, 2, 1'b0, 0, 1'b0);
`else
        // Without the timeout a stalled RAM keeps the beat in XFER
        set_txn(1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h0);
        serve(20, 20, 1'b0, 0, 1'b0);
`endif

        // Random traffic: overlapping requests, re-requests and mid-burst drops
        for (int round = 0; round < 40; round++) begin
            for (int q = 0; q < NREQ; q++) begin
                if (!pend[q] && $urandom_range(0, 2) == 0) new_txn(q);
            end
            if (exp_winner() < 0) new_txn($urandom_range(0, NREQ - 1));
            serve(0, 3, 1'($urandom_range(0, 1)), 50, 1'b1);
        end
        while (exp_winner() >= 0) serve(0, 2, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
